// File: rtl/multi_channel_accumulator.sv
// rtl/multi_channel_accumulator.sv - free-running cycle counter plus NUM_CH wrap/saturate accumulators with registered read port
// Optional shadow bank (snapshot of every accumulator, overflow flag and the cycle count) enabled by ACC_SNAPSHOT_EN.
module multi_channel_accumulator #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 32,
  parameter int CYC_W    = 64,
  parameter int SAT_MODE = 0,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [CYC_W-1:0]         cycles,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_value,
  input  logic                     clr_valid,
  input  logic [SEL_W-1:0]         clr_ch,
  input  logic                     rd_en,
  input  logic [SEL_W-1:0]         rd_ch,
  input  logic                     rd_snap,
  input  logic                     snap,
  output logic                     rd_valid,
  output logic [ACC_W-1:0]         rd_data,
  output logic                     rd_ovf,
  output logic [NUM_CH-1:0]        ovf
);

  localparam int PAD_W = ACC_W + 1 - DATA_W;

  logic [ACC_W-1:0]  acc     [NUM_CH];
  logic [ACC_W-1:0]  acc_nxt [NUM_CH];
  logic [NUM_CH-1:0] ovf_nxt;
  logic [ACC_W:0]    sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 1'b1;
    end
  end

  // Clear is applied first so a same-cycle add lands on a zeroed channel.
  always_comb begin
    sum     = '0;
    ovf_nxt = ovf;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_nxt[i] = acc[i];
      if (clr_valid && (clr_ch == SEL_W'(i))) begin
        acc_nxt[i] = '0;
        ovf_nxt[i] = 1'b0;
      end
      if (in_valid[i]) begin
        sum = {1'b0, acc_nxt[i]} + {{PAD_W{1'b0}}, in_value[i*DATA_W +: DATA_W]};
        ovf_nxt[i] = ovf_nxt[i] | sum[ACC_W];
        if (sum[ACC_W] && (SAT_MODE != 0)) begin
          acc_nxt[i] = '1;
        end else begin
          acc_nxt[i] = sum[ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= acc_nxt[i];
      end
      ovf <= ovf_nxt;
    end
  end

  logic [ACC_W-1:0] live_data;
  logic             live_ovf;
  logic [ACC_W-1:0] sel_data;
  logic             sel_ovf;

  // Out-of-range channels match no entry and read back as zero.
  always_comb begin
    live_data = '0;
    live_ovf  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == SEL_W'(i)) begin
        live_data = acc[i];
        live_ovf  = ovf[i];
      end
    end
  end

`ifdef ACC_SNAPSHOT_EN
  logic [ACC_W-1:0]  snap_acc [NUM_CH];
  logic [NUM_CH-1:0] snap_ovf;
  logic [CYC_W-1:0]  snap_cycles;
  logic [ACC_W-1:0]  shadow_data;
  logic              shadow_ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_acc[i] <= '0;
      end
      snap_ovf    <= '0;
      snap_cycles <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_acc[i] <= acc[i];
      end
      snap_ovf    <= ovf;
      snap_cycles <= cycles;
    end
  end

  always_comb begin
    shadow_data = '0;
    shadow_ovf  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == SEL_W'(i)) begin
        shadow_data = snap_acc[i];
        shadow_ovf  = snap_ovf[i];
      end
    end
  end

  assign sel_data = rd_snap ? shadow_data : live_data;
  assign sel_ovf  = rd_snap ? shadow_ovf  : live_ovf;
`else
  logic unused_snap_inputs;
  assign unused_snap_inputs = &{1'b0, snap, rd_snap};
  assign sel_data = live_data;
  assign sel_ovf  = live_ovf;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= sel_data;
        rd_ovf  <= sel_ovf;
      end
    end
  end

endmodule
